// File: rtl/key_pulse_sched.sv
// Console key scheduler: sync + debounce + rising-edge latch per key, then a
// fixed-priority IDLE/FIRE/WAIT scheduler that issues one-cycle key pulses.
module key_pulse_sched #(
  parameter int NKEYS = 4,
  parameter int DEB   = 8,
  parameter int GAP   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys,
  input  logic             hold,
  output logic [NKEYS-1:0] kp,
  output logic             busy,
  output logic [NKEYS-1:0] pend
);

  localparam int CW = $clog2(DEB);
  localparam int WW = $clog2(GAP + 1);
  localparam logic [CW-1:0] DEB_TC = CW'(DEB - 1);
  localparam logic [WW-1:0] GAP_LD = WW'(GAP - 1);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} state_t;

  logic [NKEYS-1:0]         s1, s2, deb, deb_rise;
  logic [NKEYS-1:0][CW-1:0] cnt;

  state_t           state, state_nx;
  logic [WW-1:0]    wcnt, wcnt_nx;
  logic [NKEYS-1:0] kp_nx, grant, clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_TC) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is accepted on the same edge deb would flip 0->1.
  always_comb begin
    deb_rise = '0;
    for (int i = 0; i < NKEYS; i++) begin
      deb_rise[i] = ~deb[i] & s2[i] & (cnt[i] == DEB_TC);
    end
  end

  // Lowest set bit of pend: bit 0 has highest priority.
  assign grant = pend & (~pend + NKEYS'(1));

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    kp_nx    = '0;
    clr      = '0;
    case (state)
      IDLE: begin
        if ((pend != '0) && !hold) begin
          kp_nx    = grant;
          clr      = grant;
          state_nx = FIRE;
        end
      end
      FIRE: begin
        wcnt_nx  = GAP_LD;
        state_nx = WAIT;
      end
      WAIT: begin
        if (wcnt == '0) state_nx = IDLE;
        else            wcnt_nx  = wcnt - WW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
      kp    <= '0;
      busy  <= 1'b0;
      pend  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      kp    <= kp_nx;
      busy  <= (state_nx != IDLE);
      // Set wins over clear so a re-press on the issuing edge is kept.
      pend  <= (pend & ~clr) | deb_rise;
    end
  end

endmodule
